// File: rtl/uart_pkg.sv
// Shared receiver FSM encoding, register map and STATUS bit positions for uart_rx_core.
// Optional parity support (UART_RX_PARITY_EN) reuses the ST_PARITY encoding declared here.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;

  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;

  // Sticky, write-one-to-clear error bits within STATUS.
  localparam logic [7:0] ERR_MASK = 8'h1C;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_phy.sv
// Serial front end: 2-FF rxd synchronizer, 16x tick generator and frame FSM; UART_RX_PARITY_EN adds an even-parity bit.
// Emits one-cycle byte_vld/frame_err/parity_err pulses at the mid-bit sample; no backpressure, every pulse must be taken.
module uart_rx_phy
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 54
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       rxd_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxd_meta_q, rxd_sync_q;
  logic          tick;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign byte_dat_o = shift_q;
  // Divider is held in IDLE so tick phase is aligned to the detected start edge.
  assign div_cnt_d  = (state_q == ST_IDLE || tick) ? '0 : div_cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_vld_o   = 1'b0;
    frame_err_o  = 1'b0;
    parity_err_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rxd_sync_q) state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (tick_cnt_q == 4'd7) begin
          tick_cnt_d = '0;
          state_d    = rxd_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
      ST_DATA: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          parity_err_o = (rxd_sync_q != ^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          if (rxd_sync_q) begin
            byte_vld_o = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: if (rxd_sync_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver (8E1 with UART_RX_PARITY_EN) with RX FIFO and Avalon-MM DATA/STATUS registers; read latency 1.
// FIFO full on a new byte drops it and sets sticky overrun unless the same cycle pops; errors are W1C, set wins.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [3:0] avms_address_i,
  input  logic       avms_read_i,
  input  logic       avms_write_i,
  input  logic [7:0] avms_writedata_i,
  output logic [7:0] avms_readdata_o,
  input  logic       uart_rxd_i,
  output logic       rx_irq_o
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  if (DIV == 0) begin : g_div_chk
    $error("uart_rx_core: CLK_FREQ/(16*BAUD_RATE) rounds to zero");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_core: FIFO_DEPTH must be a power of two >= 2");
  end

  logic          byte_vld, frame_err, parity_err;
  logic [7:0]    byte_dat;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    err_q, err_d, readdata_q, readdata_d;
  logic [7:0]    status, set_vec, w1c_vec;
  logic          empty, full, pop, push;

  uart_rx_phy #(.DIV(DIV)) u_phy (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .rxd_i        (uart_rxd_i),
    .byte_vld_o   (byte_vld),
    .byte_dat_o   (byte_dat),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop   = avms_read_i && (avms_address_i == REG_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push  = byte_vld && (!full || pop);

  assign avms_readdata_o = readdata_q;
  assign rx_irq_o        = !empty || (|err_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    set_vec                  = '0;
    set_vec[STAT_OVERRUN]    = byte_vld && full && !pop;
    set_vec[STAT_FRAME_ERR]  = frame_err;
    set_vec[STAT_PARITY_ERR] = parity_err;
    w1c_vec = (avms_write_i && avms_address_i == REG_STATUS) ? avms_writedata_i : '0;
    err_d   = ((err_q & ~w1c_vec) | set_vec) & ERR_MASK;

    status                 = err_q;
    status[STAT_NOT_EMPTY] = !empty;
    status[STAT_FULL]      = full;

    readdata_d = readdata_q;
    if (avms_read_i) begin
      case (avms_address_i)
        REG_DATA:   readdata_d = empty ? 8'h00 : mem_q[rd_ptr_q];
        REG_STATUS: readdata_d = status;
        default:    readdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= '0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= byte_dat;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames driven at exactly 16*DIV clocks per bit, register reads checked by assertions.
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 1_000_000;
  localparam int          DIV      = 6;  // round(100e6 / (16 * 1e6)) = round(6.25)
  localparam int          BIT      = 16 * DIV;
  localparam logic [3:0]  A_DATA   = 4'h0;
  localparam logic [3:0]  A_STAT   = 4'h1;

  logic       clk   = 1'b0;
  logic       arst  = 1'b1;
  logic [3:0] addr  = 4'h0;
  logic       rd    = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rxd   = 1'b1;
  logic [7:0] rdata;
  logic       irq;
  int         vectors     = 0;
  int         miscompares = 0;
`ifdef UART_RX_PARITY_EN
  logic       bad_par = 1'b0;
`endif

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(8)) dut (
    .clk_i            (clk),
    .arst_i           (arst),
    .avms_address_i   (addr),
    .avms_read_i      (rd),
    .avms_write_i     (wr),
    .avms_writedata_i (wdata),
    .avms_readdata_o  (rdata),
    .uart_rxd_i       (rxd),
    .rx_irq_o         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic r, input logic w, input logic [7:0] wd,
                        output logic [7:0] d);
    @(negedge clk);
    addr = a; rd = r; wr = w; wdata = wd;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    d = rdata;
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_rw(a, 1'b1, 1'b0, 8'h00, d);
    check(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ bad_par;
    repeat (BIT) @(negedge clk);
`endif
    rxd = stop;
    repeat (BIT) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] pb;

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    expect_reg("idle_status", A_STAT, 8'h00);

    // Two good frames
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    expect_reg("two_status", A_STAT, 8'h01);
    check("two_irq", {7'd0, irq}, 8'h01);
    expect_reg("data_55", A_DATA, 8'h55);
    expect_reg("data_a3", A_DATA, 8'hA3);
    expect_reg("drained_status", A_STAT, 8'h00);
    check("drained_irq", {7'd0, irq}, 8'h00);

    // Short low glitch must not start a frame
    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    expect_reg("glitch_status", A_STAT, 8'h00);
    check("glitch_irq", {7'd0, irq}, 8'h00);

    // Bad stop bit, then break held for two frames
    send_frame(8'h3C, 1'b0);
    expect_reg("ferr_status", A_STAT, 8'h08);
    check("ferr_irq", {7'd0, irq}, 8'h01);
    repeat (20 * BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h12, 1'b1);
    expect_reg("after_break_status", A_STAT, 8'h09);
    expect_reg("data_12", A_DATA, 8'h12);
    bus_rw(A_STAT, 1'b0, 1'b1, 8'h08, d);
    expect_reg("ferr_cleared", A_STAT, 8'h00);

    // Overfill: nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    expect_reg("ovr_status", A_STAT, 8'h07);
    repeat (5) @(negedge clk);
    check("rd_hold", rdata, 8'h07);
    expect_reg("rd_other_addr", 4'h5, 8'h00);
    bus_rw(A_DATA, 1'b0, 1'b1, 8'hAA, d);
    for (int i = 1; i <= 8; i++) expect_reg("fifo_data", A_DATA, 8'(i));
    expect_reg("empty_read", A_DATA, 8'h00);
    // Simultaneous read and W1C: read sees pre-clear value
    bus_rw(A_STAT, 1'b1, 1'b1, 8'h04, d);
    check("rw_status_pre", d, 8'h04);
    expect_reg("ovr_cleared", A_STAT, 8'h00);

    // Reset in the middle of a frame
    send_frame(8'h33, 1'b1);
    expect_reg("pre_rst_status", A_STAT, 8'h01);
    pb = 8'h5A;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = pb[i];
      repeat (BIT) @(negedge clk);
    end
    arst = 1'b1;
    @(negedge clk);
    check("midrst_rdata", rdata, 8'h00);
    check("midrst_irq", {7'd0, irq}, 8'h00);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    expect_reg("post_rst_status", A_STAT, 8'h00);
    send_frame(8'h7E, 1'b1);
    expect_reg("frame_7e_status", A_STAT, 8'h01);
    expect_reg("data_7e", A_DATA, 8'h7E);
    expect_reg("final_status", A_STAT, 8'h00);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    expect_reg("par_status", A_STAT, 8'h11);
    expect_reg("par_data", A_DATA, 8'h07);
    bus_rw(A_STAT, 1'b0, 1'b1, 8'h10, d);
    expect_reg("par_cleared", A_STAT, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
